// File: rtl/mem_bus_arbiter.sv
// Round-robin N-master bridge onto one synchronous-read memory port.
// Translates guest addresses by MEM_BASE and answers out-of-range accesses with an error.
module mem_bus_arbiter #(
    parameter int             NUM_MASTERS = 2,
    parameter int             AW          = 32,
    parameter int             DW          = 32,
    parameter int             MW          = 4,
    parameter logic [AW-1:0]  MEM_BASE    = 32'h8000_0000,
    parameter logic [AW-1:0]  MEM_SIZE    = 32'h0800_0000,
    parameter int             MEM_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_MASTERS-1:0]    m_req,
    input  logic [NUM_MASTERS-1:0]    m_we,
    input  logic [NUM_MASTERS*AW-1:0] m_addr,
    input  logic [NUM_MASTERS*DW-1:0] m_wdata,
    input  logic [NUM_MASTERS*MW-1:0] m_mask,
    output logic [NUM_MASTERS-1:0]    m_ready,
    output logic                      m_err,
    output logic [DW-1:0]             m_rdata,
    output logic                      mem_ce,
    output logic                      mem_we,
    output logic [AW-1:0]             mem_addr,
    output logic [DW-1:0]             mem_wdata,
    output logic [MW-1:0]             mem_mask,
    input  logic [DW-1:0]             mem_rdata,
    output logic                      busy
);

    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam logic [GW-1:0] LAST_INIT = GW'(NUM_MASTERS - 1);
    localparam logic [AW:0]   BASE_EXT  = {1'b0, MEM_BASE};
    localparam logic [AW:0]   SIZE_EXT  = {1'b0, MEM_SIZE};

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    state_t                   state_reg, state_next;
    logic [GW-1:0]            last_reg, last_next;
    logic [GW-1:0]            grant_reg, grant_next;
    logic                     we_reg, we_next;
    logic [CW-1:0]            cnt_reg, cnt_next;
    logic [NUM_MASTERS-1:0]   ready_reg, ready_next;
    logic                     err_reg, err_next;
    logic [DW-1:0]            rdata_reg, rdata_next;
    logic                     ce_reg, ce_next;
    logic                     mem_we_reg, mem_we_next;
    logic [AW-1:0]            mem_addr_reg, mem_addr_next;
    logic [DW-1:0]            mem_wdata_reg, mem_wdata_next;
    logic [MW-1:0]            mem_mask_reg, mem_mask_next;
    logic                     busy_reg, busy_next;

    logic [AW-1:0] addr_arr  [NUM_MASTERS];
    logic [DW-1:0] wdata_arr [NUM_MASTERS];
    logic [MW-1:0] mask_arr  [NUM_MASTERS];

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
            assign addr_arr[gi]  = m_addr[gi*AW +: AW];
            assign wdata_arr[gi] = m_wdata[gi*DW +: DW];
            assign mask_arr[gi]  = m_mask[gi*MW +: MW];
        end
    endgenerate

    // Search starts one past the previous winner so a waiting master is always next.
    logic          found;
    logic [GW-1:0] winner;
    int            idx;
    always_comb begin
        found  = 1'b0;
        winner = last_reg;
        idx    = 0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = (int'(last_reg) + k) % NUM_MASTERS;
            if (!found && m_req[GW'(idx)]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end
    end

    // One extra bit keeps addresses near the top of the space from wrapping into range.
    logic [AW-1:0] sel_addr;
    logic [AW:0]   sel_ext;
    logic          in_range;
    assign sel_addr = addr_arr[winner];
    assign sel_ext  = {1'b0, sel_addr};
    assign in_range = (sel_ext >= BASE_EXT) && ((sel_ext - BASE_EXT) < SIZE_EXT);

    always_comb begin
        state_next     = state_reg;
        last_next      = last_reg;
        grant_next     = grant_reg;
        we_next        = we_reg;
        cnt_next       = cnt_reg;
        ready_next     = '0;
        err_next       = 1'b0;
        rdata_next     = '0;
        ce_next        = 1'b0;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_mask_next  = mem_mask_reg;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    last_next  = winner;
                    grant_next = winner;
                    we_next    = m_we[winner];
                    if (in_range) begin
                        state_next     = ACCESS;
                        ce_next        = 1'b1;
                        cnt_next       = CW'(MEM_LATENCY);
                        mem_we_next    = m_we[winner];
                        mem_addr_next  = sel_addr - MEM_BASE;
                        mem_wdata_next = wdata_arr[winner];
                        mem_mask_next  = mask_arr[winner];
                    end else begin
                        state_next         = RESP;
                        ready_next[winner] = 1'b1;
                        err_next           = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // Count reaches zero in the cycle read data arrives, MEM_LATENCY after mem_ce.
                if (cnt_reg == '0) begin
                    state_next            = RESP;
                    ready_next[grant_reg] = 1'b1;
                    rdata_next            = we_reg ? '0 : mem_rdata;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            last_reg      <= LAST_INIT;
            grant_reg     <= '0;
            we_reg        <= 1'b0;
            cnt_reg       <= '0;
            ready_reg     <= '0;
            err_reg       <= 1'b0;
            rdata_reg     <= '0;
            ce_reg        <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_mask_reg  <= '0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            last_reg      <= last_next;
            grant_reg     <= grant_next;
            we_reg        <= we_next;
            cnt_reg       <= cnt_next;
            ready_reg     <= ready_next;
            err_reg       <= err_next;
            rdata_reg     <= rdata_next;
            ce_reg        <= ce_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_mask_reg  <= mem_mask_next;
            busy_reg      <= busy_next;
        end
    end

    assign m_ready   = ready_reg;
    assign m_err     = err_reg;
    assign m_rdata   = rdata_reg;
    assign mem_ce    = ce_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_mask  = mem_mask_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed corner cases plus randomized two-master traffic,
// all cycles checked against a transaction-level timing and memory model.
module tb_mem_bus_arbiter;

    localparam int          N    = 2;
    localparam int          LAT  = 3;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] SIZE = 32'h0800_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  m_req, m_we, m_ready;
    logic [N*32-1:0] m_addr, m_wdata;
    logic [N*4-1:0]  m_mask;
    logic          m_err, mem_ce, mem_we, busy;
    logic [31:0]   m_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]    mem_mask;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(
        .NUM_MASTERS(N), .AW(32), .DW(32), .MW(4),
        .MEM_BASE(BASE), .MEM_SIZE(SIZE), .MEM_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_mask(m_mask), .m_ready(m_ready), .m_err(m_err),
        .m_rdata(m_rdata), .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] mask);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (mask[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // Memory responder: data for a read appears exactly LAT cycles after mem_ce, noise otherwise.
    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] rd_pipe [0:LAT];
    assign mem_rdata = rd_pipe[LAT];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : dflt(a);
    endfunction

    always @(negedge clk) begin
        for (int k = LAT; k > 0; k--) rd_pipe[k] = rd_pipe[k-1];
        if (mem_ce && mem_we) begin
            mem_arr[mem_addr] = merge(mem_read(mem_addr), mem_wdata, mem_mask);
            rd_pipe[0] = $urandom;
        end else if (mem_ce) begin
            rd_pipe[0] = mem_read(mem_addr);
        end else begin
            rd_pipe[0] = $urandom;
        end
    end

    // Reference model: transaction timing from the grant cycle, shadow memory by offset.
    logic [31:0] shadow [logic [31:0]];
    function automatic logic [31:0] sh_read(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : dflt(a);
    endfunction

    int          ncyc = 0;
    int          t_s = 0, t_end = -1, win = 0, last = N - 1, ntxn = 0;
    logic        act = 1'b0, t_inr = 1'b0, t_we = 1'b0;
    logic [31:0] t_off = '0, t_wdata = '0, t_rd = '0;
    logic [3:0]  t_mask = '0;
    logic [N-1:0] rdy_seen = '0;

    always @(negedge clk) begin
        logic       exp_busy, exp_ce;
        logic [N-1:0] exp_rdy;
        logic [31:0] a;
        int best, bestd, d;
        ncyc++;
        rdy_seen = m_ready;
        if (rst) begin
            chk("rst_m_ready", m_ready, 0);   chk("rst_m_err", m_err, 0);
            chk("rst_m_rdata", m_rdata, 0);   chk("rst_mem_ce", mem_ce, 0);
            chk("rst_mem_we", mem_we, 0);     chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0); chk("rst_mem_mask", mem_mask, 0);
            chk("rst_busy", busy, 0);
            last  = N - 1;
            act   = 1'b0;
            t_end = -1;
        end else begin
            exp_busy = act && ncyc > t_s && ncyc <= t_end;
            exp_ce   = act && t_inr && ncyc == t_s + 1;
            exp_rdy  = (act && ncyc == t_end) ? N'(1 << win) : '0;
            chk("busy", busy, exp_busy);
            chk("mem_ce", mem_ce, exp_ce);
            chk("m_ready", m_ready, exp_rdy);
            if (exp_ce) begin
                chk("mem_we", mem_we, t_we);
                chk("mem_addr", mem_addr, t_off);
                chk("mem_wdata", mem_wdata, t_wdata);
                chk("mem_mask", mem_mask, t_mask);
            end
            if (exp_rdy != 0) begin
                chk("m_err", m_err, !t_inr);
                chk("m_rdata", m_rdata, (t_inr && !t_we) ? t_rd : 32'h0);
                $display("txn %0d: master %0d %s off=%h err=%0b rdata=%h cycle=%0d",
                         ntxn, win, t_we ? "WR" : "RD", t_off, m_err, m_rdata, ncyc);
                ntxn++;
            end
            if ((!act || ncyc > t_end) && m_req != 0) begin
                best = 0; bestd = N;
                for (int i = 0; i < N; i++) begin
                    d = (i - last - 1 + 2 * N) % N;
                    if (m_req[i] && d < bestd) begin best = i; bestd = d; end
                end
                win     = best;
                last    = best;
                a       = m_addr[best*32 +: 32];
                t_inr   = (longint'(a) >= longint'(BASE)) &&
                          (longint'(a) < longint'(BASE) + longint'(SIZE));
                t_we    = m_we[best];
                t_off   = a - BASE;
                t_wdata = m_wdata[best*32 +: 32];
                t_mask  = m_mask[best*4 +: 4];
                if (t_inr && t_we) shadow[t_off] = merge(sh_read(t_off), t_wdata, t_mask);
                if (t_inr && !t_we) t_rd = sh_read(t_off);
                t_s   = ncyc;
                t_end = t_inr ? ncyc + 2 + LAT : ncyc + 1;
                act   = 1'b1;
            end
        end
    end

    task automatic set_fields(input int i, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] mask);
        m_we[i]            = we;
        m_addr[i*32 +: 32]  = addr;
        m_wdata[i*32 +: 32] = wdata;
        m_mask[i*4 +: 4]    = mask;
    endtask

    task automatic rand_fields(input int i);
        logic [31:0] a;
        case ($urandom % 8)
            0, 1, 2, 3: a = BASE + 32'(4 * ($urandom % 16));
            4:          a = BASE + SIZE - 32'(4 + 4 * ($urandom % 4));
            5:          a = BASE - 32'(4 + 4 * ($urandom % 4));
            6:          a = BASE + SIZE + 32'(4 * ($urandom % 4));
            default:    a = 32'hFFFF_FFFC - 32'(4 * ($urandom % 2));
        endcase
        set_fields(i, 1'($urandom % 2), a, $urandom, 4'($urandom % 16));
    endtask

    // One isolated transaction; cycle numbers are counted from the request cycle (0).
    task automatic run_one(input int m, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask,
                           output int ce_cyc, output int ce_cnt, output int rdy_cyc,
                           output logic [N-1:0] rdy, output logic err, output logic [31:0] rdata,
                           output logic [31:0] ce_addr, output logic ce_we, output logic [3:0] ce_mask);
        @(posedge clk); #1;
        set_fields(m, we, addr, wdata, mask);
        m_req[m] = 1'b1;
        ce_cyc = -1; ce_cnt = 0; rdy_cyc = -1; rdy = '0; err = 1'b0; rdata = '0;
        ce_addr = '0; ce_we = 1'b0; ce_mask = '0;
        for (int c = 0; c < 20 && rdy_cyc < 0; c++) begin
            @(negedge clk);
            if (mem_ce) begin
                ce_cnt++;
                if (ce_cyc < 0) begin
                    ce_cyc = c; ce_addr = mem_addr; ce_we = mem_we; ce_mask = mem_mask;
                end
            end
            if (m_ready != 0) begin
                rdy_cyc = c; rdy = m_ready; err = m_err; rdata = m_rdata;
            end
        end
        @(posedge clk); #1;
        m_req[m] = 1'b0;
    endtask

    initial begin
        int ce_cyc, ce_cnt, rdy_cyc, n;
        logic [N-1:0] rdy, first_rdy;
        logic err, ce_we;
        logic [31:0] rdata, ce_addr;
        logic [3:0] ce_mask;
        logic [N-1:0] grants [6];

        rst = 1'b1;
        m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_mask = '0;
        for (int k = 0; k <= LAT; k++) rd_pipe[k] = '0;
        mem_arr[32'h10] = 32'hDEAD_BEEF;
        shadow[32'h10]  = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Both masters request back to back from reset.
        @(posedge clk); #1;
        set_fields(0, 1'b0, BASE + 32'h20, 32'h0, 4'h0);
        set_fields(1, 1'b0, BASE + 32'h24, 32'h0, 4'h0);
        m_req = 2'b11;
        n = 0;
        for (int c = 0; c < 100 && n < 6; c++) begin
            @(negedge clk);
            if (m_ready != 0) begin grants[n] = m_ready; n++; end
        end
        @(posedge clk); #1 m_req = '0;
        chk("rr_count", 64'(n), 64'd6);
        for (int k = 0; k < n; k++)
            chk($sformatf("rr_grant%0d", k), grants[k], (k % 2) ? 2'b10 : 2'b01);

        run_one(0, 1'b0, 32'h8000_0010, 32'h0, 4'hF, ce_cyc, ce_cnt, rdy_cyc, rdy, err, rdata, ce_addr, ce_we, ce_mask);
        chk("rd_ce_cycle", 64'(ce_cyc), 64'd1);
        chk("rd_ce_addr", ce_addr, 32'h10);
        chk("rd_ready_cycle", 64'(rdy_cyc), 64'(2 + LAT));
        chk("rd_ready", rdy, 2'b01);
        chk("rd_rdata", rdata, 32'hDEAD_BEEF);

        run_one(1, 1'b1, 32'h8000_0100, 32'h1234_5678, 4'b0011, ce_cyc, ce_cnt, rdy_cyc, rdy, err, rdata, ce_addr, ce_we, ce_mask);
        chk("wr_ce_count", 64'(ce_cnt), 64'd1);
        chk("wr_ce_we", ce_we, 1'b1);
        chk("wr_ce_addr", ce_addr, 32'h100);
        chk("wr_ce_mask", ce_mask, 4'b0011);
        chk("wr_ready", rdy, 2'b10);
        chk("wr_ready_cycle", 64'(rdy_cyc), 64'(2 + LAT));

        run_one(1, 1'b0, 32'h8000_0100, 32'h0, 4'h0, ce_cyc, ce_cnt, rdy_cyc, rdy, err, rdata, ce_addr, ce_we, ce_mask);
        chk("wr_readback", rdata, 32'h5A5A_5678);

        run_one(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'hF, ce_cyc, ce_cnt, rdy_cyc, rdy, err, rdata, ce_addr, ce_we, ce_mask);
        chk("oor_lo_ce", 64'(ce_cnt), 64'd0);
        chk("oor_lo_cycle", 64'(rdy_cyc), 64'd1);
        chk("oor_lo_err", err, 1'b1);
        chk("oor_lo_rdata", rdata, 32'h0);
        run_one(1, 1'b0, 32'h8800_0000, 32'h0, 4'hF, ce_cyc, ce_cnt, rdy_cyc, rdy, err, rdata, ce_addr, ce_we, ce_mask);
        chk("oor_hi_ce", 64'(ce_cnt), 64'd0);
        chk("oor_hi_cycle", 64'(rdy_cyc), 64'd1);
        chk("oor_hi_err", err, 1'b1);
        run_one(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, ce_cyc, ce_cnt, rdy_cyc, rdy, err, rdata, ce_addr, ce_we, ce_mask);
        chk("oor_top_err", err, 1'b1);
        run_one(1, 1'b0, 32'h87FF_FFFC, 32'h0, 4'hF, ce_cyc, ce_cnt, rdy_cyc, rdy, err, rdata, ce_addr, ce_we, ce_mask);
        chk("last_word_err", err, 1'b0);
        chk("last_word_rdata", rdata, 32'h5DA5_F0F3);

        run_one(0, 1'b1, 32'h8000_0040, 32'hFFFF_FFFF, 4'h0, ce_cyc, ce_cnt, rdy_cyc, rdy, err, rdata, ce_addr, ce_we, ce_mask);
        chk("mask0_ce_count", 64'(ce_cnt), 64'd1);
        chk("mask0_mem_mask", ce_mask, 4'h0);
        run_one(0, 1'b0, 32'h8000_0040, 32'h0, 4'h0, ce_cyc, ce_cnt, rdy_cyc, rdy, err, rdata, ce_addr, ce_we, ce_mask);
        chk("mask0_readback", rdata, 32'h5A5A_0F4F);

        // Reset in the cycle after mem_ce; master 0 was the last winner.
        @(posedge clk); #1;
        set_fields(0, 1'b0, BASE + 32'h8, 32'h0, 4'h0);
        m_req = 2'b01;
        @(negedge clk); @(negedge clk);
        chk("mid_rst_ce_before", mem_ce, 1'b1);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", m_ready, 2'b00);
        chk("mid_rst_ce", mem_ce, 1'b0);
        set_fields(1, 1'b0, BASE + 32'hC, 32'h0, 4'h0);
        m_req = 2'b11;
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        first_rdy = '0;
        for (int c = 0; c < 20 && first_rdy == 0; c++) begin
            @(negedge clk);
            if (m_ready != 0) first_rdy = m_ready;
        end
        chk("post_rst_first_grant", first_rdy, 2'b01);
        @(posedge clk); #1 m_req = '0;

        // Randomized traffic: each master reacts to its own m_ready the following cycle.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (m_req[i] && rdy_seen[i]) begin
                    if ($urandom % 3 == 0) m_req[i] = 1'b0;
                    else rand_fields(i);
                end else if (!m_req[i]) begin
                    if ($urandom % 2 == 1) begin rand_fields(i); m_req[i] = 1'b1; end
                end else if ($urandom % 64 == 0) begin
                    m_req[i] = 1'b0;
                end
            end
        end
        m_req = '0;
        repeat (12) @(posedge clk);
        chk("random_txn_seen", 64'(ntxn > 100), 64'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
